mem_arbiter: RTL and testbench

Two-requester controller that shares the single-port, combinationally-read word memory between the CPU's instruction-fetch path (port I, read-only) and load/store path (port D, read/write). It arbitrates with a round-robin policy and sequences each access through a fixed three-state FSM. It converts byte addresses to word indices, checks alignment and range, and returns registered responses over valid/ready handshakes. It sits between the core's fetch/LSU stages and the memory array.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam int WORD_BYTES = 4;

    // Misaligned byte address or word index beyond the last word of the array.
    function automatic logic addr_err(input logic [31:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = fetch port, bit 1 = data port.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prefer_d_r;
    logic last_d_r;

    // One-hot grant; a contested cycle goes to the side not served last.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prefer_d_r ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // req is only non-zero while the owner is ready to accept, so any grant is a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_d_r <= 1'b1;
            last_d_r   <= 1'b0;
        end else begin
            if (req != 2'b00) begin
                last_d_r <= grant[1];
            end
            if (advance) begin
                prefer_d_r <= !last_d_r;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one combinationally-read word memory between the fetch (I) and load/store (D) ports.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_valid,
    output logic             i_req_ready,
    input  logic [31:0]      i_req_addr,
    output logic             i_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      i_rsp_data,
    output logic             i_rsp_err,
    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic [31:0]      d_req_addr,
    input  logic             d_req_we,
    input  logic [31:0]      d_req_wdata,
    output logic             d_rsp_valid,
    input  logic             d_rsp_ready,
    output logic [31:0]      d_rsp_data,
    output logic             d_rsp_err,
    output logic [IDX_W-1:0] mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    state_t      state_r;
    req_id_t     id_r;
    logic [31:0] addr_r;
    logic        we_r;
    logic [31:0] wdata_r;
    logic [31:0] rsp_data_r;
    logic        rsp_err_r;
    logic        i_rsp_valid_r;
    logic        d_rsp_valid_r;
    logic [1:0]  req_s;
    logic [1:0]  grant_s;
    logic        err_s;
    logic        idle_s;

    assign idle_s = (state_r == IDLE);
    assign req_s  = idle_s ? {d_req_valid, i_req_valid} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     (req_s),
        .advance (state_r == ACCESS),
        .grant   (grant_s)
    );

    // Handshake readies and the memory strobe, which is live only during ACCESS.
    always_comb begin
        i_req_ready = idle_s && grant_s[0];
        d_req_ready = idle_s && grant_s[1];
        err_s       = addr_err(addr_r, DEPTH);
        if (state_r == ACCESS) begin
            mem_addr  = addr_r[IDX_W+1:2];
            mem_we    = we_r && !err_s;
            mem_wdata = wdata_r;
        end else begin
            mem_addr  = {IDX_W{1'b0}};
            mem_we    = 1'b0;
            mem_wdata = 32'h0000_0000;
        end
    end

    // Request latch, access sequencing and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            id_r          <= REQ_D;
            addr_r        <= 32'h0000_0000;
            we_r          <= 1'b0;
            wdata_r       <= 32'h0000_0000;
            rsp_data_r    <= 32'h0000_0000;
            rsp_err_r     <= 1'b0;
            i_rsp_valid_r <= 1'b0;
            d_rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s != 2'b00) begin
                        id_r    <= grant_s[1] ? REQ_D : REQ_I;
                        addr_r  <= grant_s[1] ? d_req_addr : i_req_addr;
                        we_r    <= grant_s[1] && d_req_we;
                        wdata_r <= grant_s[1] ? d_req_wdata : 32'h0000_0000;
                        state_r <= ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_data_r <= (we_r || err_s) ? 32'h0000_0000 : mem_rdata;
                    rsp_err_r  <= err_s;
                    if (id_r == REQ_D) begin
                        d_rsp_valid_r <= 1'b1;
                    end else begin
                        i_rsp_valid_r <= 1'b1;
                    end
                    state_r <= RESP;
                end
                RESP: begin
                    if ((d_rsp_valid_r && d_rsp_ready) || (i_rsp_valid_r && i_rsp_ready)) begin
                        d_rsp_valid_r <= 1'b0;
                        i_rsp_valid_r <= 1'b0;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign i_rsp_valid = i_rsp_valid_r;
    assign i_rsp_data  = rsp_data_r;
    assign i_rsp_err   = rsp_err_r;
    assign d_rsp_valid = d_rsp_valid_r;
    assign d_rsp_data  = rsp_data_r;
    assign d_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;

    localparam int DEPTH = 32;
    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
    logic [31:0]      i_req_addr, i_rsp_data;
    logic             d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0]      d_req_addr, d_req_wdata, d_rsp_data;
    logic [IDX_W-1:0] mem_addr;
    logic             mem_we;
    logic [31:0]      mem_wdata, mem_rdata;

    logic [31:0] bench_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        mem_init;
    int          wr_count;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
        .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
        .d_rsp_err(d_rsp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory array the DUT drives.
    assign mem_rdata = bench_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < DEPTH; k++) bench_mem[k] <= 32'hA500_0000 + 32'(k);
            wr_count <= 0;
        end else if (mem_we === 1'b1) begin
            bench_mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // ---------------- reference model: one transaction, aged in cycles since its handshake
    bit          m_on = 1'b0;
    bit          m_busy = 1'b0;
    int          m_age;
    bit          m_id_d;
    logic [31:0] m_addr, m_wdata, m_data;
    bit          m_we, m_err;
    bit          m_prefer_d = 1'b1;
    bit          log_on = 1'b0;
    int          grant_log[$];

    function automatic int winner_now();
        if (i_req_valid && d_req_valid) return m_prefer_d ? 2 : 1;
        if (d_req_valid) return 2;
        if (i_req_valid) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        int  w;
        bit  acc, rsp, ok_store;
        w        = winner_now();
        acc      = m_busy && (m_age == 1);
        rsp      = m_busy && (m_age == 2);
        ok_store = m_we && !m_err;
        if (m_on) begin
            check1("i_req_ready", i_req_ready, !m_busy && (w == 1));
            check1("d_req_ready", d_req_ready, !m_busy && (w == 2));
            check1("mem_we", mem_we, acc && ok_store);
            check32("mem_addr", 32'(mem_addr), acc ? 32'(m_addr / 4 % DEPTH) : 32'h0);
            check32("mem_wdata", mem_wdata, acc ? m_wdata : 32'h0);
            check1("i_rsp_valid", i_rsp_valid, rsp && !m_id_d);
            check1("d_rsp_valid", d_rsp_valid, rsp && m_id_d);
            if (rsp && m_id_d) begin
                check32("d_rsp_data", d_rsp_data, m_data);
                check1("d_rsp_err", d_rsp_err, m_err);
            end
            if (rsp && !m_id_d) begin
                check32("i_rsp_data", i_rsp_data, m_data);
                check1("i_rsp_err", i_rsp_err, m_err);
            end
        end
        // advance the model through the coming rising edge
        if (rst) begin
            if (!m_on) begin
                for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'hA500_0000 + 32'(k);
            end else if (acc && ok_store) begin
                ref_mem[m_addr / 4] = m_wdata;
            end
            m_busy     = 1'b0;
            m_prefer_d = 1'b1;
            m_on       = 1'b1;
        end else if (m_on) begin
            if (m_busy) begin
                if (m_age == 1) begin
                    if (ok_store) ref_mem[m_addr / 4] = m_wdata;
                    m_age = 2;
                end else if ((m_id_d && d_rsp_ready) || (!m_id_d && i_rsp_ready)) begin
                    m_busy = 1'b0;
                end
            end else if (w != 0) begin
                m_busy     = 1'b1;
                m_age      = 1;
                m_id_d     = (w == 2);
                m_addr     = m_id_d ? d_req_addr : i_req_addr;
                m_we       = m_id_d && d_req_we;
                m_wdata    = m_id_d ? d_req_wdata : 32'h0;
                m_err      = (m_addr % 4 != 0) || (m_addr / 4 >= DEPTH);
                m_data     = (m_we || m_err) ? 32'h0 : ref_mem[m_addr / 4];
                m_prefer_d = !m_id_d;
                if (log_on) grant_log.push_back(w);
            end
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input bit is_d, input logic [31:0] addr, input logic we,
                           input logic [31:0] wd, output logic [31:0] data,
                           output logic err, output int lat);
        bit ok;
        data = 32'h0; err = 1'b0; lat = 0;
        if (is_d) begin
            d_req_valid = 1'b1; d_req_addr = addr; d_req_we = we; d_req_wdata = wd;
        end else begin
            i_req_valid = 1'b1; i_req_addr = addr;
        end
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (is_d ? d_req_ready : i_req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            timeout("req_ready");
            d_req_valid = 1'b0; i_req_valid = 1'b0;
            return;
        end
        tick();
        if (is_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;
        ok = 1'b0; lat = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (is_d ? d_rsp_valid : i_rsp_valid) begin ok = 1'b1; break; end
            lat++;
        end
        if (!ok) begin
            timeout("rsp_valid");
            return;
        end
        data = is_d ? d_rsp_data : i_rsp_data;
        err  = is_d ? d_rsp_err : i_rsp_err;
        tick();
    endtask

    task automatic wait_signal(input bit is_d_rsp, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (is_d_rsp ? d_rsp_valid : d_req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_i_rsp_valid"}, i_rsp_valid, 1'b0);
        check1({tag, "_d_rsp_valid"}, d_rsp_valid, 1'b0);
        check32({tag, "_d_rsp_data"}, d_rsp_data, 32'h0);
        check1({tag, "_d_rsp_err"}, d_rsp_err, 1'b0);
        check1({tag, "_mem_we"}, mem_we, 1'b0);
        check32({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        check32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        logic [31:0] data, held;
        logic        err;
        int          lat, wc0;

        rst = 1'b1; mem_init = 1'b1;
        i_req_valid = 1'b0; i_req_addr = 32'h0; i_rsp_ready = 1'b1;
        d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_we = 1'b0; d_req_wdata = 32'h0;
        d_rsp_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        check32("reset_i_rsp_data", i_rsp_data, 32'h0);
        repeat (5) tick();

        // store then load back through D
        run_req(1'b1, 32'h10, 1'b1, 32'hDEAD_BEEF, data, err, lat);
        check32("store_data", data, 32'h0);
        check32("store_latency", 32'(lat), 32'd2);
        check32("store_mem_word4", bench_mem[4], 32'hDEAD_BEEF);
        run_req(1'b1, 32'h10, 1'b0, 32'h0, data, err, lat);
        check32("load_data", data, 32'hDEAD_BEEF);
        check1("load_err", err, 1'b0);
        check32("load_latency", 32'(lat), 32'd2);

        // contention from reset: D, I, D, I
        rst = 1'b1; tick(); rst = 1'b0;
        log_on = 1'b1;
        i_req_valid = 1'b1; i_req_addr = 32'h7C;
        d_req_valid = 1'b1; d_req_addr = 32'h10; d_req_we = 1'b0;
        repeat (11) tick();
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (3) tick();
        log_on = 1'b0;
        check32("grant_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() >= 4) begin
            check32("grant0_D", 32'(grant_log[0]), 32'd2);
            check32("grant1_I", 32'(grant_log[1]), 32'd1);
            check32("grant2_D", 32'(grant_log[2]), 32'd2);
            check32("grant3_I", 32'(grant_log[3]), 32'd1);
        end

        // error boundaries
        wc0 = wr_count;
        run_req(1'b1, 32'h12, 1'b1, 32'h5555_5555, data, err, lat);
        check1("misaligned_err", err, 1'b1);
        check32("misaligned_data", data, 32'h0);
        run_req(1'b0, 32'h80, 1'b0, 32'h0, data, err, lat);
        check1("range_err", err, 1'b1);
        check32("range_data", data, 32'h0);
        check32("err_no_write", 32'(wr_count - wc0), 32'd0);
        run_req(1'b0, 32'h7C, 1'b0, 32'h0, data, err, lat);
        check32("last_word_data", data, 32'hA500_001F);
        check1("last_word_err", err, 1'b0);

        // D response backpressure with I waiting
        d_rsp_ready = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h04;
        d_req_valid = 1'b1; d_req_addr = 32'h10; d_req_we = 1'b0;
        @(negedge clk);
        check1("bp_d_wins", d_req_ready, 1'b1);
        tick();
        d_req_valid = 1'b0;
        wait_signal(1'b1, "bp_rsp_valid");
        held = d_rsp_data;
        check32("bp_data", held, 32'hDEAD_BEEF);
        for (int n = 0; n < 5; n++) begin
            tick();
            @(negedge clk);
            check1("bp_valid_held", d_rsp_valid, 1'b1);
            check32("bp_data_stable", d_rsp_data, held);
            check1("bp_i_blocked", i_req_ready, 1'b0);
        end
        tick();
        d_rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check1("bp_i_granted_next", i_req_ready, 1'b1);
        tick();
        i_req_valid = 1'b0;
        repeat (4) tick();

        // reset while in RESP
        d_rsp_ready = 1'b0;
        d_req_valid = 1'b1; d_req_addr = 32'h10; d_req_we = 1'b0;
        wait_signal(1'b0, "rstresp_ready");
        tick();
        d_req_valid = 1'b0;
        wait_signal(1'b1, "rstresp_valid");
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        d_rsp_ready = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_resp");

        // reset coinciding with a store's ACCESS cycle
        tick();
        wc0 = wr_count;
        d_req_valid = 1'b1; d_req_addr = 32'h08; d_req_we = 1'b1; d_req_wdata = 32'h1234_5678;
        wait_signal(1'b0, "rstacc_ready");
        tick();
        d_req_valid = 1'b0; d_req_we = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_access");
        repeat (4) tick();
        check32("rst_access_writes", 32'(wr_count - wc0), 32'd1);
        check32("rst_access_word2", bench_mem[2], 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
